// File: rtl/shared_reg_arbiter_if.sv
// rtl/shared_reg_arbiter_if.sv - requester-side bus of the shared register arbiter
interface shared_reg_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_i;
    logic [NUM_REQ*DATA_W-1:0] data_i;
    logic [NUM_REQ-1:0]        gnt_o;
    logic [NUM_REQ-1:0]        ack_o;
    logic [DATA_W-1:0]         q_o;
    logic                      q_valid_o;
    logic                      busy_o;

    modport master (
        output req_i, data_i,
        input  gnt_o, ack_o, q_o, q_valid_o, busy_o
    );

    modport slave (
        input  req_i, data_i,
        output gnt_o, ack_o, q_o, q_valid_o, busy_o
    );
endinterface

// File: rtl/shared_reg_arbiter.sv
// rtl/shared_reg_arbiter.sv - round-robin write arbiter for one shared register
module shared_reg_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 8
) (
    input logic                 clk,
    input logic                 reset,
    shared_reg_arbiter_if.slave bus
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_ACK   = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [PTR_W-1:0]     ptr_q, ptr_d;
    logic [PTR_W-1:0]     win_q, win_d;
    logic [NUM_REQ-1:0]   gnt_q, gnt_d;
    logic [NUM_REQ-1:0]   ack_q, ack_d;
    logic [DATA_W-1:0]    q_q, q_d;
    logic                 qv_q, qv_d;

    logic                 rr_hit;
    logic [PTR_W-1:0]     rr_idx;
    logic [PTR_W-1:0]     cand_idx;
    int                   cand;

    // Search starts at ptr and wraps explicitly so non-power-of-2 NUM_REQ works.
    always_comb begin
        rr_hit   = 1'b0;
        rr_idx   = '0;
        cand     = 0;
        cand_idx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = int'(ptr_q) + i;
            if (cand >= NUM_REQ) begin
                cand = cand - NUM_REQ;
            end
            cand_idx = PTR_W'(cand);
            if (!rr_hit && bus.req_i[cand_idx]) begin
                rr_hit = 1'b1;
                rr_idx = cand_idx;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        win_d   = win_q;
        gnt_d   = gnt_q;
        ack_d   = '0;
        q_d     = q_q;
        qv_d    = qv_q;
        case (state_q)
            S_IDLE: begin
                if (rr_hit) begin
                    win_d   = rr_idx;
                    gnt_d   = {{(NUM_REQ-1){1'b0}}, 1'b1} << rr_idx;
                    state_d = S_GRANT;
                end
            end
            S_GRANT: begin
                gnt_d = '0;
                // A withdrawn request abandons the slot without moving the pointer.
                if (bus.req_i[win_q]) begin
                    q_d     = bus.data_i[win_q*DATA_W +: DATA_W];
                    ack_d   = gnt_q;
                    qv_d    = 1'b1;
                    ptr_d   = (win_q == LAST_IDX) ? '0 : win_q + 1'b1;
                    state_d = S_ACK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                gnt_d   = '0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            win_q   <= '0;
            gnt_q   <= '0;
            ack_q   <= '0;
            q_q     <= '0;
            qv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            win_q   <= win_d;
            gnt_q   <= gnt_d;
            ack_q   <= ack_d;
            q_q     <= q_d;
            qv_q    <= qv_d;
        end
    end

    assign bus.gnt_o     = gnt_q;
    assign bus.ack_o     = ack_q;
    assign bus.q_o       = q_q;
    assign bus.q_valid_o = qv_q;
    assign bus.busy_o    = (state_q != S_IDLE);

    a_gnt_ack_excl: assert property (@(posedge clk) disable iff (!reset)
        !((|gnt_q) && (|ack_q)));
    a_gnt_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(gnt_q));
    a_ack_onehot0: assert property (@(posedge clk) disable iff (!reset)
        $onehot0(ack_q));
endmodule

// File: tb/tb_shared_reg_arbiter.sv
// tb/tb_shared_reg_arbiter.sv - scoreboard bench for shared_reg_arbiter
module tb_shared_reg_arbiter;
    localparam int NR = 4;
    localparam int DW = 8;

    logic clk;
    logic reset;
    int   cyc;
    int   n_tests;
    int   n_fail;

    typedef struct {
        logic [NR-1:0] ack;
        logic [DW-1:0] q;
    } exp_ack_t;

    logic [NR-1:0] exp_gnt_q[$];
    exp_ack_t      exp_ack_q[$];
    int            ack_cyc[$];
    logic [NR-1:0] mon_g;
    exp_ack_t      mon_a;

    shared_reg_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) dut_if ();

    shared_reg_arbiter #(.NUM_REQ(NR), .DATA_W(DW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dut_if.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT shows a grant or an ack.
    always @(negedge clk) begin
        if (dut_if.gnt_o != '0) begin
            if (exp_gnt_q.size() == 0) begin
                check("unexpected_gnt", 32'(dut_if.gnt_o), 32'h0);
            end else begin
                mon_g = exp_gnt_q.pop_front();
                check("gnt", 32'(dut_if.gnt_o), 32'(mon_g));
            end
        end
        if (dut_if.ack_o != '0) begin
            ack_cyc.push_back(cyc);
            if (exp_ack_q.size() == 0) begin
                check("unexpected_ack", 32'(dut_if.ack_o), 32'h0);
            end else begin
                mon_a = exp_ack_q.pop_front();
                check("ack", 32'(dut_if.ack_o), 32'(mon_a.ack));
                check("ack_q", 32'(dut_if.q_o), 32'(mon_a.q));
                check("ack_q_valid", 32'(dut_if.q_valid_o), 32'h1);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic set_slice(input int k, input logic [DW-1:0] v);
        dut_if.data_i[k*DW +: DW] = v;
    endtask

    task automatic expect_write(input logic [NR-1:0] m, input logic [DW-1:0] v);
        exp_ack_t e;
        e.ack = m;
        e.q   = v;
        exp_gnt_q.push_back(m);
        exp_ack_q.push_back(e);
    endtask

    task automatic write_one(input logic [NR-1:0] m, input logic [DW-1:0] v, input int k);
        set_slice(k, v);
        expect_write(m, v);
        dut_if.req_i = m;
        step();
        step();
        dut_if.req_i = '0;
        step();
    endtask

    initial begin
        int busy_cnt;
        int n0;
        n_tests = 0;
        n_fail  = 0;
        cyc     = 0;
        reset   = 1'b0;
        dut_if.req_i  = '0;
        dut_if.data_i = '0;

        @(negedge clk);
        check("reset_state", 32'({dut_if.gnt_o, dut_if.ack_o, dut_if.q_o,
              dut_if.q_valid_o, dut_if.busy_o}), 32'h0);
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        step();

        // single requester
        set_slice(1, 8'hA5);
        expect_write(4'b0010, 8'hA5);
        dut_if.req_i = 4'b0010;
        busy_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (dut_if.busy_o) busy_cnt++;
            if (i == 2) dut_if.req_i = '0;
        end
        check("busy_cycles", 32'(busy_cnt), 32'd2);
        step();

        // async reset in the middle of a GRANT cycle
        write_one(4'b0001, 8'h55, 0);
        set_slice(2, 8'h66);
        exp_gnt_q.push_back(4'b0100);
        dut_if.req_i = 4'b0100;
        step();
        @(negedge clk);
        #1;
        check("q_before_reset", 32'(dut_if.q_o), 32'h55);
        check("busy_in_grant", 32'(dut_if.busy_o), 32'h1);
        reset = 1'b0;
        #1;
        check("async_reset_clear", 32'({dut_if.gnt_o, dut_if.ack_o, dut_if.q_o,
              dut_if.q_valid_o, dut_if.busy_o}), 32'h0);
        dut_if.req_i = '0;
        repeat (2) @(posedge clk);
        #2;
        reset = 1'b1;
        step();

        // withdraw during grant
        set_slice(0, 8'h3C);
        exp_gnt_q.push_back(4'b0001);
        dut_if.req_i = 4'b0001;
        step();
        dut_if.req_i = '0;
        step();
        step();
        check("withdraw_q", 32'(dut_if.q_o), 32'h0);
        check("withdraw_q_valid", 32'(dut_if.q_valid_o), 32'h0);
        check("withdraw_busy", 32'(dut_if.busy_o), 32'h0);

        // full contention from ptr 0 (proves ptr stayed 0 after withdraw)
        for (int k = 0; k < NR; k++) set_slice(k, 8'h10 + 8'(k));
        expect_write(4'b0001, 8'h10);
        expect_write(4'b0010, 8'h11);
        expect_write(4'b0100, 8'h12);
        expect_write(4'b1000, 8'h13);
        expect_write(4'b0001, 8'h10);
        n0 = ack_cyc.size();
        dut_if.req_i = 4'b1111;
        repeat (14) step();
        dut_if.req_i = '0;
        repeat (3) step();
        check("contention_ack_count", 32'(ack_cyc.size() - n0), 32'd5);
        if (ack_cyc.size() == n0 + 5) begin
            for (int i = 1; i < 5; i++)
                check("contention_interval", 32'(ack_cyc[n0+i] - ack_cyc[n0+i-1]), 32'd3);
        end

        // pointer wrap: write by 2 leaves ptr at 3
        write_one(4'b0100, 8'h22, 2);
        set_slice(0, 8'hA0);
        set_slice(1, 8'hB1);
        expect_write(4'b0001, 8'hA0);
        expect_write(4'b0010, 8'hB1);
        dut_if.req_i = 4'b0011;
        repeat (5) step();
        dut_if.req_i = '0;
        repeat (2) step();

        // idle hold
        write_one(4'b0001, 8'h7E, 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("idle_hold", 32'({dut_if.gnt_o, dut_if.ack_o, dut_if.q_o,
                  dut_if.q_valid_o, dut_if.busy_o}),
                  32'({4'b0000, 4'b0000, 8'h7E, 1'b1, 1'b0}));
        end

        check("gnt_queue_drained", 32'(exp_gnt_q.size()), 32'd0);
        check("ack_queue_drained", 32'(exp_ack_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/shared_reg_arbiter.md
Name: shared_reg_arbiter

Overview:
- Round-robin arbiter and write sequencer for one shared DATA_W-bit register bank built from asynchronously reset flip-flops.
- NUM_REQ requesters compete for write access.
- The block grants one requester at a time and captures that requester's data into the shared register.
- It acknowledges the write and then advances the fairness pointer.
- It sits between the requester-side logic and the shared storage flops. The register value is exported to all consumers.

Parameters:
NUM_REQ  4  number of requesters, >= 2
DATA_W  8  width of the shared register and of each requester's data

Ports:
clk  input  1  single clock, all state updates on rising edge
reset  input  1  asynchronous, active-low reset: reset = 0 clears all state immediately
req_i  input  NUM_REQ  write request, one bit per requester, level-sensitive
data_i  input  NUM_REQ*DATA_W  packed write data; requester k occupies bits [k*DATA_W +: DATA_W]
gnt_o  output  NUM_REQ  one-hot grant, asserted during GRANT state only
ack_o  output  NUM_REQ  one-hot single-cycle write-complete pulse
q_o  output  DATA_W  shared register contents
q_valid_o  output  1  high once any write has completed since reset
busy_o  output  1  high whenever state != IDLE

Behaviour:
- Reset values (reset = 0, asynchronous): state IDLE, ptr 0, gnt_o 0, ack_o 0, q_o 0, q_valid_o 0, busy_o 0. Asserting reset mid-transaction aborts that transaction: no capture, no ack.
- FSM states: IDLE, GRANT, ACK. All outputs are registered or decoded from registered state only. No combinational path from req_i or data_i to outputs.
- IDLE:
  - If req_i != 0 at the rising edge, select a winner by round-robin search: indices ptr, ptr+1, ... mod NUM_REQ; the first set bit wins.
  - Register gnt to one-hot(winner) and move to GRANT.
  - If req_i == 0, stay in IDLE.
- GRANT (exactly 1 cycle): gnt_o = gnt. The requester must hold req and data stable during this cycle. At the closing edge:
  - If req_i[winner] = 1: q_o <= data_i slice of winner; ack_o <= gnt; q_valid_o <= 1; ptr <= (winner+1) mod NUM_REQ; go to ACK.
  - If req_i[winner] = 0 (withdrawn): no capture, no ack, ptr unchanged, go to IDLE.
  - Other requesters' req changes during GRANT are ignored.
- ACK (exactly 1 cycle): ack_o one-hot pulse, gnt_o = 0. Next edge: ack_o <= 0, go to IDLE unconditionally. A requester still holding req is re-arbitrated in IDLE.
- Timing and throughput:
  - Latency from req sampled in IDLE to q_o updated: 2 edges.
  - Maximum throughput: one write per 3 cycles.
- Fairness: a requester that completes a write becomes lowest priority. With all requesters constantly requesting, grants rotate 0,1,...,NUM_REQ-1,0. Pointer wrap is mod NUM_REQ.
- Output invariants:
  - q_o is unchanged except at a successful GRANT-closing edge. It holds its value indefinitely otherwise.
  - gnt_o and ack_o are never both nonzero. Each is zero or one-hot at all times.
- Width rule: no arithmetic on data. The pointer is ceil(log2(NUM_REQ)) bits, with explicit wrap for non-power-of-2 NUM_REQ.

Test Plan:
- Reset then single requester: reset=0 for 2 cycles, then release; req_i=4'b0010, data_i slice1=8'hA5 -> gnt_o=0010 one cycle, then ack_o=0010 one cycle with q_o=8'hA5 and q_valid_o=1; busy_o high for exactly 2 cycles.
- Full contention: req_i=4'b1111 held, slice k = 8'h10+k -> grant order 0,1,2,3,0; q_o sequence 10,11,12,13,10; one write every 3 cycles.
- Pointer wrap: after a completed write by requester 2 (ptr=3), req_i=4'b0011 -> requester 0 granted, then requester 1; no grant to 2 or 3.
- Withdraw during grant: req_i=4'b0001 with data 8'h3C granted, then req_i dropped in GRANT cycle -> no ack_o, q_o keeps its previous value, ptr stays 0, FSM returns to IDLE.
- Async reset mid-operation: assert reset=0 between edges while in GRANT with q_o=8'h55 -> gnt_o, ack_o, q_o, q_valid_o, busy_o go to 0 immediately without a clock edge; after release, the first write behaves as from power-up.
- Idle hold: req_i=0 for 20 cycles after a write of 8'h7E -> q_o stays 8'h7E, q_valid_o=1, gnt_o=ack_o=0, busy_o=0.
